// File: rtl/spi_per.sv
// SPI mode-0 responder: oversamples DCLK/CS/COPI in the clk_in domain, receives one
// DATA_WIDTH-bit word per CS-low frame and shifts a preloaded word out on CIPO.
module spi_per #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load_in,
  output logic                  tx_ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  underrun_out,
  output logic                  frame_err_out,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  input  logic                  chip_data_in,
  output logic                  chip_data_out,
  output logic                  chip_data_en_out,
  output logic [1:0]            state_dbg_out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                r_state, w_next_state;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_cs_sync, r_copi_sync;
  logic                  r_clk_d, r_cs_d;
  logic [DATA_WIDTH-1:0] r_buf, r_shift_tx;
  logic                  r_buf_full;
  logic [DATA_WIDTH-2:0] r_rx;
  logic [CW-1:0]         r_bit_cnt;

  logic w_s_clk, w_s_cs, w_s_copi;
  logic w_clk_rise, w_clk_fall, w_cs_rise, w_cs_fall;
  logic w_start, w_sample, w_last, w_drive, w_abort, w_release;
  logic [DATA_WIDTH-1:0] w_tx_word, w_rx_next;

  // Synchronisers reset to the idle bus: DCLK low, CS high, COPI low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_clk_sync  <= '0;
      r_cs_sync   <= '1;
      r_copi_sync <= '0;
      r_clk_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], chip_clk_in};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], chip_sel_in};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], chip_data_in};
      r_clk_d     <= w_s_clk;
      r_cs_d      <= w_s_cs;
    end
  end

  assign w_s_clk    = r_clk_sync[SYNC_STAGES-1];
  assign w_s_cs     = r_cs_sync[SYNC_STAGES-1];
  assign w_s_copi   = r_copi_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_s_clk & ~r_clk_d;
  assign w_clk_fall = ~w_s_clk & r_clk_d;
  assign w_cs_rise  = w_s_cs & ~r_cs_d;
  assign w_cs_fall  = ~w_s_cs & r_cs_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_cs_fall) w_next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (w_cs_rise)                               w_next_state = ST_IDLE;
        else if (w_clk_rise && r_bit_cnt == LAST_BIT) w_next_state = ST_WAIT;
      end
      ST_WAIT:  if (w_cs_rise) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // CS edges take priority over DCLK edges seen in the same cycle.
  always_comb begin
    w_start   = 1'b0;
    w_sample  = 1'b0;
    w_last    = 1'b0;
    w_drive   = 1'b0;
    w_abort   = 1'b0;
    w_release = 1'b0;
    case (r_state)
      ST_IDLE:  w_start = w_cs_fall;
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_abort = 1'b1;
        end else if (w_clk_rise) begin
          w_sample = 1'b1;
          w_last   = (r_bit_cnt == LAST_BIT);
        end else if (w_clk_fall) begin
          w_drive = 1'b1;
        end
      end
      ST_WAIT:  w_release = w_cs_rise;
      default:  ;
    endcase
  end

  assign w_tx_word     = r_buf_full ? r_buf : '0;
  assign w_rx_next     = {r_rx, w_s_copi};
  assign tx_ready_out  = ~r_buf_full;
  assign state_dbg_out = r_state;

  // A load coinciding with frame start refills the buffer for the following frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (load_in) begin
      r_buf      <= data_in;
      r_buf_full <= 1'b1;
    end else if (w_start) begin
      r_buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_shift_tx       <= '0;
      r_rx             <= '0;
      r_bit_cnt        <= '0;
      data_out         <= '0;
      data_valid_out   <= 1'b0;
      underrun_out     <= 1'b0;
      frame_err_out    <= 1'b0;
      chip_data_out    <= 1'b0;
      chip_data_en_out <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      underrun_out   <= 1'b0;
      frame_err_out  <= w_abort;
      if (w_start) begin
        r_shift_tx       <= w_tx_word;
        chip_data_out    <= w_tx_word[DATA_WIDTH-1];
        chip_data_en_out <= 1'b1;
        r_bit_cnt        <= '0;
        r_rx             <= '0;
        underrun_out     <= ~r_buf_full;
      end
      if (w_sample) begin
        r_rx      <= w_rx_next[DATA_WIDTH-2:0];
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (w_last) begin
          data_out       <= w_rx_next;
          data_valid_out <= 1'b1;
        end
      end
      if (w_drive) begin
        r_shift_tx    <= r_shift_tx << 1;
        chip_data_out <= r_shift_tx[DATA_WIDTH-2];
      end
      if (w_abort || w_release) begin
        chip_data_out    <= 1'b0;
        chip_data_en_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_per.md
Name: spi_per

Overview:
- SPI peripheral (responder) matching our SPI controller: mode 0, MSB first, active-low CS, full duplex.
- Oversamples DCLK, CS and COPI in the system clock domain and deserialises one DATA_WIDTH-bit word per CS-low frame.
- Shifts a preloaded transmit word out on CIPO during the same frame.
- Used on the receiving FPGA / test-harness side of the encryptor link.

Parameters:
- DATA_WIDTH, 8, bits per frame (≥2).
- SYNC_STAGES, 2, flops in each input synchroniser (≥2).

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_n_in  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  word to send on the next frame.
- load_in  input  1  one-cycle strobe; captures data_in into the tx buffer.
- tx_ready_out  output  1  high when the tx buffer is empty and can accept load_in.
- data_out  output  DATA_WIDTH  last complete word received.
- data_valid_out  output  1  one-cycle pulse, data_out new.
- underrun_out  output  1  one-cycle pulse: frame started with an empty tx buffer.
- frame_err_out  output  1  one-cycle pulse: CS deasserted mid-word.
- chip_clk_in  input  1  DCLK from controller.
- chip_sel_in  input  1  CS, active low.
- chip_data_in  input  1  COPI.
- chip_data_out  output  1  CIPO.
- chip_data_en_out  output  1  CIPO drive enable (high while selected).

Behaviour:
- Reset (rst_n_in low, asynchronous): data_out=0, data_valid_out=0, underrun_out=0, frame_err_out=0, chip_data_out=0, chip_data_en_out=0, tx_ready_out=1. Synchronisers reset to idle: DCLK=0, CS=1, COPI=0. tx buffer empty; FSM in IDLE.
- Synchronisers: each chip input passes through SYNC_STAGES flops (s_x), plus one delay flop s_x_d.
  - Edge events: rise = s_x & ~s_x_d; fall = ~s_x & s_x_d.
  - A pin edge is detected SYNC_STAGES..SYNC_STAGES+1 cycles later.
- Timing requirement: DCLK high and low times ≥ SYNC_STAGES+3 clk_in cycles each; CS low-to-first-DCLK-rise ≥ same. Behaviour is undefined otherwise.
- TX buffer:
  - load_in while tx_ready_out=1: buffer=data_in, tx_ready_out=0 next cycle.
  - load_in while tx_ready_out=0: overwrites the buffer (latest wins).
  - Buffer consumed at frame start; tx_ready_out=1 the cycle after consumption.
  - load_in in the same cycle as consumption loads the next-frame word; the current frame uses the old buffer.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on CS fall:
    - shift_tx = buffer, or all zeros with underrun_out pulsed if the buffer is empty.
    - chip_data_out = MSB of the loaded value; chip_data_en_out=1.
    - bit_cnt=0; rx shift register cleared.
  - SHIFT, DCLK rise:
    - rx = {rx[DATA_WIDTH-2:0], s_copi}; bit_cnt++.
    - If bit_cnt becomes DATA_WIDTH: data_out=new rx and data_valid_out=1 next cycle; go to IDLE-wait (remain selected, ignore further edges until CS rise).
  - SHIFT, DCLK fall (bit_cnt<DATA_WIDTH): chip_data_out = next bit of shift_tx (MSB-first order).
  - CS rise in SHIFT with bit_cnt<DATA_WIDTH: frame_err_out pulse; no data_valid_out; data_out unchanged; -> IDLE.
  - CS rise after a complete word: -> IDLE, no error.
  - On any exit to IDLE: chip_data_en_out=0, chip_data_out=0.
- Simultaneous events:
  - CS rise and DCLK rise detected in the same cycle: CS wins; the bit is discarded.
  - CS fall and DCLK edge in the same cycle: the DCLK edge is ignored.
- Extra DCLK rises after DATA_WIDTH bits in one frame are ignored (only one word per CS frame).
- The bit counter is wide enough for DATA_WIDTH ($clog2(DATA_WIDTH+1)) and never wraps.
- Pulse outputs are never high two consecutive cycles.

Test Plan:
- Nominal: load 8'hA5; controller sends 8'h3C with DCLK half-period 50 -> data_out=8'h3C with a single data_valid_out pulse; controller receives 8'hA5; tx_ready_out returns 1 after CS fall.
- Back-to-back: load 8'h01, frame, load 8'h80 during frame, frame -> CIPO words 8'h01 then 8'h80; RX words match both sent values; no underrun.
- Underrun: no load, frame sending 8'hFF -> underrun_out pulse at CS fall, CIPO all zeros, data_out=8'hFF valid.
- Abort: CS raised after 5 DCLK rises -> frame_err_out pulse, no data_valid_out, data_out holds its previous value, chip_data_en_out=0; next full frame 8'h5A received correctly.
- Async reset mid-frame: assert rst_n_in low between clk_in edges after 3 bits -> all outputs at reset values immediately; release, full frame 8'hC3 received correctly.
- Min timing: DCLK half-period = SYNC_STAGES+3 cycles, random words over 100 frames -> all RX/TX words correct.
